// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sequencer that owns the shared SPI peripheral's
// register bus (CTRL/STAT/DATA) on behalf of NREQ requesters. Each granted
// transaction: assert the requester's cs_n, enable the peripheral with its cfg,
// stream bytes (write DATA, poll STAT.RXNE, read DATA), then release cs_n and
// disable the peripheral.
// Optional feature: define SPI_ARB_TIMEOUT_EN to bound POLL to TIMEOUT cycles
// per byte; an expired byte is reported with rx_err and ends the transaction.
//
// state   | meaning
// IDLE    | no transaction, waiting for any req
// ARB     | pick next requester round-robin from ptr
// CFG     | write CTRL = cfg | EN_MASK, drop winner's cs_n
// SETUP   | cs_n setup delay before first byte
// WAIT_TX | waiting for winner's tx_valid, bus quiet
// WR      | write DATA with winner's byte, pulse tx_ready
// POLL    | read STAT until RXNE
// RD      | read DATA, return byte on rx_data
// HOLD    | cs_n hold delay after last byte
// DIS     | write CTRL = 0, raise cs_n, drop grant
module spi_arbiter #(
  parameter int                NREQ      = 3,
  parameter int                DATA_N    = 8,
  parameter int                ADDR_W    = 2,
  parameter logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(2),
  parameter int                RXNE_BIT  = 1,
  parameter logic [DATA_N-1:0] EN_MASK   = DATA_N'(8'h80),
  parameter int                CS_SETUP  = 2,
  parameter int                CS_HOLD   = 2,
  parameter int                TIMEOUT   = 4096
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_N-1:0] cfg,
  input  logic [NREQ*DATA_N-1:0] tx_data,
  input  logic [NREQ-1:0]        tx_valid,
  input  logic [NREQ-1:0]        tx_last,
  output logic [NREQ-1:0]        tx_ready,
  output logic [NREQ-1:0]        gnt,
  output logic                   rx_valid,
  output logic [DATA_N-1:0]      rx_data,
  output logic                   rx_err,
  output logic [NREQ-1:0]        cs_n,
  output logic                   periph_sel,
  output logic [ADDR_W-1:0]      periph_addr,
  output logic                   bus_we,
  output logic                   bus_oe,
  output logic [DATA_N-1:0]      bus_wdata,
  input  logic [DATA_N-1:0]      bus_rdata
);

  localparam int PTR_W   = $clog2(NREQ);
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || RXNE_BIT >= DATA_N) begin : g_param_check
    $error("spi_arbiter: parameter out of range");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_CFG, S_SETUP, S_WAIT_TX, S_WR, S_POLL, S_RD, S_HOLD, S_DIS
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   arb_idx;
  logic [PTR_W-1:0]   cand;
  logic               arb_hit;
  logic [CNT_W-1:0]   cnt;
  logic               last_q;
  logic               go_wr;
  logic [DATA_N-1:0]  cfg_sel;
  logic [DATA_N-1:0]  tx_sel;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]   tmo_cnt;
`endif

  assign cfg_sel = cfg[win*DATA_N +: DATA_N];
  assign tx_sel  = tx_data[win*DATA_N +: DATA_N];

  // Start a byte whenever the winner has data and the CS setup time is met;
  // this lets CFG/SETUP jump straight to WR without a WAIT_TX cycle.
  assign go_wr = tx_valid[win] &&
                 ((state == S_CFG && CS_SETUP == 0) ||
                  (state == S_SETUP && cnt == CNT_W'(1)) ||
                  (state == S_WAIT_TX));

  // Round-robin search: first set req starting at ptr, wrapping mod NREQ.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Peripheral bus strobes are a pure decode of the current state.
  always_comb begin
    bus_we      = 1'b0;
    bus_oe      = 1'b0;
    periph_addr = '0;
    bus_wdata   = '0;
    case (state)
      S_CFG:  begin bus_we = 1'b1; periph_addr = ADDR_CTRL; bus_wdata = cfg_sel | EN_MASK; end
      S_WR:   begin bus_we = 1'b1; periph_addr = ADDR_DATA; bus_wdata = tx_sel; end
      S_POLL: begin bus_oe = 1'b1; periph_addr = ADDR_STAT; end
      S_RD:   begin bus_oe = 1'b1; periph_addr = ADDR_DATA; end
      S_DIS:  begin bus_we = 1'b1; periph_addr = ADDR_CTRL; end
      default: ;
    endcase
  end

  assign periph_sel = bus_we | bus_oe;

  // Transaction sequencer with registered grant, chip selects and rx path.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      win      <= '0;
      cnt      <= '0;
      last_q   <= 1'b0;
      gnt      <= '0;
      cs_n     <= '1;
      tx_ready <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_err   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      tx_ready <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (go_wr) begin
        tx_ready[win] <= 1'b1;
        last_q        <= tx_last[win];
      end
      case (state)
        S_IDLE: if (|req) state <= S_ARB;
        S_ARB: begin
          if (arb_hit) begin
            gnt   <= NREQ'(1) << arb_idx;
            win   <= arb_idx;
            ptr   <= (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            state <= S_CFG;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CFG: begin
          cs_n[win] <= 1'b0;
          cnt       <= CNT_W'(CS_SETUP);
          if (CS_SETUP == 0) state <= go_wr ? S_WR : S_WAIT_TX;
          else               state <= S_SETUP;
        end
        S_SETUP: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= go_wr ? S_WR : S_WAIT_TX;
        end
        S_WAIT_TX: if (go_wr) state <= S_WR;
        S_WR: begin
          state <= S_POLL;
`ifdef SPI_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        S_POLL: begin
          if (bus_rdata[RXNE_BIT]) begin
            state <= S_RD;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            // Abandon the byte and the rest of the transaction.
            rx_valid <= 1'b1;
            rx_err   <= 1'b1;
            rx_data  <= '0;
            cnt      <= CNT_W'(CS_HOLD);
            state    <= (CS_HOLD != 0) ? S_HOLD : S_DIS;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_RD: begin
          rx_data  <= bus_rdata;
          rx_valid <= 1'b1;
          if (last_q) begin
            cnt   <= CNT_W'(CS_HOLD);
            state <= (CS_HOLD != 0) ? S_HOLD : S_DIS;
          end else begin
            state <= S_WAIT_TX;
          end
        end
        S_HOLD: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_DIS;
        end
        S_DIS: begin
          cs_n  <= '1;
          gnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a default instance (CS_SETUP=2, CS_HOLD=2)
// with a behavioural peripheral, and a zero-setup/zero-hold instance.
`timescale 1ns/1ps
module tb_spi_arbiter;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic [2:0]  req, tx_valid, tx_last, tx_ready, gnt, cs_n;
  logic [23:0] cfg, tx_data;
  logic        rx_valid, rx_err, periph_sel, bus_we, bus_oe;
  logic [7:0]  rx_data, bus_wdata, bus_rdata;
  logic [1:0]  periph_addr;

  spi_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .n_reset(n_reset), .req(req), .cfg(cfg), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready), .gnt(gnt),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .cs_n(cs_n),
    .periph_sel(periph_sel), .periph_addr(periph_addr), .bus_we(bus_we),
    .bus_oe(bus_oe), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // zero setup / hold instance
  logic [2:0]  b_req, b_tx_valid, b_tx_last, b_tx_ready, b_gnt, b_cs_n;
  logic [23:0] b_cfg, b_tx_data;
  logic        b_rx_valid, b_rx_err, b_periph_sel, b_bus_we, b_bus_oe;
  logic [7:0]  b_rx_data, b_bus_wdata, b_bus_rdata;
  logic [1:0]  b_periph_addr;

  spi_arbiter #(.CS_SETUP(0), .CS_HOLD(0)) dut0 (
    .clk(clk), .n_reset(n_reset), .req(b_req), .cfg(b_cfg), .tx_data(b_tx_data),
    .tx_valid(b_tx_valid), .tx_last(b_tx_last), .tx_ready(b_tx_ready), .gnt(b_gnt),
    .rx_valid(b_rx_valid), .rx_data(b_rx_data), .rx_err(b_rx_err), .cs_n(b_cs_n),
    .periph_sel(b_periph_sel), .periph_addr(b_periph_addr), .bus_we(b_bus_we),
    .bus_oe(b_bus_oe), .bus_wdata(b_bus_wdata), .bus_rdata(b_bus_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    int r = -1;
    for (int i = 0; i < 3; i++) if (v[i]) r = i;
    return r;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: RXNE rises ~10 cycles after a DATA write, DATA reads
  // return the written byte with nibbles swapped.
  logic       rxne_dis = 1'b0;
  int         rxne_cnt = -1;
  logic [7:0] last_wr = 8'h00;
  logic [7:0] ctrl_log[$];

  always @(posedge clk) begin
    if (bus_we && periph_addr == 2'd0) ctrl_log.push_back(bus_wdata);
    if (bus_we && periph_addr == 2'd2) begin
      last_wr  <= bus_wdata;
      rxne_cnt <= rxne_dis ? -1 : 10;
    end else if (bus_oe && periph_addr == 2'd2) begin
      rxne_cnt <= -1;
    end else if (rxne_cnt > 0) begin
      rxne_cnt <= rxne_cnt - 1;
    end
  end

  always_comb begin
    bus_rdata = 8'h00;
    if (bus_oe && periph_addr == 2'd1) bus_rdata[1] = (rxne_cnt == 0);
    else if (bus_oe && periph_addr == 2'd2) bus_rdata = {last_wr[3:0], last_wr[7:4]};
  end

  always_comb begin
    b_bus_rdata = 8'h00;
    if (b_bus_oe) b_bus_rdata = (b_periph_addr == 2'd1) ? 8'h02 : 8'h99;
  end

  // Requester model for the default instance.
  logic [7:0] tb_byte [3][4];
  logic       tb_lastf[3][4];
  int         n_b[3];
  int         pos[3];
  logic [2:0] stall = 3'b000;
  logic [2:0] rdy_s, b_rdy_s;

  task automatic drive_req();
    for (int i = 0; i < 3; i++) begin
      req[i]          = pos[i] < n_b[i];
      tx_valid[i]     = (pos[i] < n_b[i]) && !stall[i];
      tx_data[i*8+:8] = (pos[i] < n_b[i]) ? tb_byte[i][pos[i]] : 8'h00;
      tx_last[i]      = (pos[i] < n_b[i]) && tb_lastf[i][pos[i]];
    end
  endtask

  always begin
    @(posedge clk);
    rdy_s   = tx_ready;
    b_rdy_s = b_tx_ready;
    #1;
    for (int i = 0; i < 3; i++) if (rdy_s[i]) pos[i]++;
    if (rdy_s != 3'b000) drive_req();
    if (b_rdy_s[0]) begin b_req = 3'b000; b_tx_valid = 3'b000; end
  end

  // Monitors, sampled on the falling edge.
  int         two_low, poll_n, cfg_cyc, wr_cyc, rd_cyc, dis_cyc, cs_low_cyc;
  int         rdy_n[3];
  int         gnt_log[$];
  logic [7:0] rx_d[$];
  logic [2:0] rx_g[$];
  logic       rx_e[$];
  logic       wr_pend = 1'b0;
  logic [2:0] gnt_prev = 3'b000;
  logic [2:0] cs_prev = 3'b111;
  int         b_cfg_cyc, b_wr_cyc, b_rd_cyc, b_dis_cyc;
  logic       b_dis_seen = 1'b0;
  logic [7:0] b_rx = 8'h00;

  always @(negedge clk) begin
    if ($countones(~cs_n) > 1) two_low++;
    if (gnt != 3'b000 && gnt_prev == 3'b000) gnt_log.push_back(oh_idx(gnt));
    gnt_prev = gnt;
    if (cs_n != 3'b111 && cs_prev == 3'b111) cs_low_cyc = cyc;
    cs_prev = cs_n;
    if (bus_we && periph_addr == 2'd0 && bus_wdata != 8'h00) begin cfg_cyc = cyc; wr_pend = 1'b1; end
    if (bus_we && periph_addr == 2'd2 && wr_pend) begin wr_cyc = cyc; wr_pend = 1'b0; end
    if (bus_oe && periph_addr == 2'd2) rd_cyc = cyc;
    if (bus_we && periph_addr == 2'd0 && bus_wdata == 8'h00) dis_cyc = cyc;
    if (bus_oe && periph_addr == 2'd1) poll_n++;
    for (int i = 0; i < 3; i++) if (tx_ready[i]) rdy_n[i]++;
    if (rx_valid) begin rx_d.push_back(rx_data); rx_g.push_back(gnt); rx_e.push_back(rx_err); end
    if (b_bus_we && b_periph_addr == 2'd0 && b_bus_wdata != 8'h00) b_cfg_cyc = cyc;
    if (b_bus_we && b_periph_addr == 2'd2) b_wr_cyc = cyc;
    if (b_bus_oe && b_periph_addr == 2'd2) b_rd_cyc = cyc;
    if (b_bus_we && b_periph_addr == 2'd0 && b_bus_wdata == 8'h00) begin b_dis_cyc = cyc; b_dis_seen = 1'b1; end
    if (b_rx_valid) b_rx = b_rx_data;
  end

  task automatic clear_logs();
    two_low = 0; poll_n = 0; cfg_cyc = 0; wr_cyc = 0; rd_cyc = 0; dis_cyc = 0; cs_low_cyc = 0;
    for (int i = 0; i < 3; i++) begin rdy_n[i] = 0; pos[i] = 0; n_b[i] = 0; end
    gnt_log.delete(); rx_d.delete(); rx_g.delete(); rx_e.delete(); ctrl_log.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!(req == 3'b000 && gnt == 3'b000 && cs_n == 3'b111) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] rxd_at(input int i);
    return (i < rx_d.size()) ? rx_d[i] : 8'hEE;
  endfunction

  initial begin
    int n;
    int exp_g[4];
    logic [7:0] exp_d[4];
    logic [2:0] exp_m[4];
    int bus_act, cs_bad, gnt_bad;

    clear_logs();
    cfg = 24'h0; drive_req();
    b_req = 3'b000; b_tx_valid = 3'b000; b_tx_last = 3'b000; b_tx_data = 24'h0; b_cfg = 24'h0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 3'b111);
    check("rst_gnt", gnt, 3'b000);
    check("rst_strobes", {periph_sel, bus_we, bus_oe}, 3'b000);
    check("rst_rx", {rx_valid, rx_err, rx_data}, 10'h0);
    check("rst_tx_ready", tx_ready, 3'b000);
    check("rst_b", {b_cs_n, b_gnt, b_periph_sel, b_rx_err}, {3'b111, 3'b000, 2'b00});
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // round robin, all three requesting, one-byte transactions
    clear_logs();
    cfg = 24'h30_20_10;
    tb_byte[0][0] = 8'h40; tb_lastf[0][0] = 1'b1;
    tb_byte[0][1] = 8'h41; tb_lastf[0][1] = 1'b1; n_b[0] = 2;
    tb_byte[1][0] = 8'h50; tb_lastf[1][0] = 1'b1; n_b[1] = 1;
    tb_byte[2][0] = 8'h60; tb_lastf[2][0] = 1'b1; n_b[2] = 1;
    drive_req();
    wait_done("rr", 600);
    exp_g = '{0, 1, 2, 0};
    exp_d = '{8'h04, 8'h05, 8'h06, 8'h14};
    exp_m = '{3'b001, 3'b010, 3'b100, 3'b001};
    check("rr_ngrants", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_order%0d", i), (i < gnt_log.size()) ? gnt_log[i] : -1, exp_g[i]);
      check($sformatf("rr_rx%0d", i), rxd_at(i), exp_d[i]);
      check($sformatf("rr_rxgnt%0d", i), (i < rx_g.size()) ? rx_g[i] : 3'b111, exp_m[i]);
    end
    check("rr_two_low", two_low, 0);
    check("rr_nctrl", ctrl_log.size(), 8);
    check("rr_ctrl2", (ctrl_log.size() > 2) ? ctrl_log[2] : 8'hEE, 8'hA0);
    check("rr_ctrl5", (ctrl_log.size() > 5) ? ctrl_log[5] : 8'hEE, 8'h00);

    // single requester 0, two bytes
    clear_logs();
    cfg[7:0] = 8'h03;
    tb_byte[0][0] = 8'hA5; tb_lastf[0][0] = 1'b0;
    tb_byte[0][1] = 8'h3C; tb_lastf[0][1] = 1'b1; n_b[0] = 2;
    drive_req();
    wait_done("one", 300);
    check("one_gnt", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    check("one_ctrl_en", (ctrl_log.size() > 0) ? ctrl_log[0] : 8'hEE, 8'h83);
    check("one_ctrl_dis", (ctrl_log.size() > 1) ? ctrl_log[1] : 8'hEE, 8'h00);
    check("one_nrx", rx_d.size(), 2);
    check("one_rx0", rxd_at(0), 8'h5A);
    check("one_rx1", rxd_at(1), 8'hC3);
    check("one_rxerr", (rx_e.size() > 1) ? {rx_e[0], rx_e[1]} : 2'b11, 2'b00);
    check("one_cs_fall", cs_low_cyc - cfg_cyc, 1);
    check("one_setup", wr_cyc - cfg_cyc, 3);
    check("one_hold", dis_cyc - rd_cyc, 3);

    // requester 1 withholds tx_valid for 20 cycles mid-transaction
    clear_logs();
    cfg[15:8] = 8'h05;
    tb_byte[1][0] = 8'h1E; tb_lastf[1][0] = 1'b0;
    tb_byte[1][1] = 8'h2D; tb_lastf[1][1] = 1'b1; n_b[1] = 2;
    drive_req();
    n = 0;
    while (!tx_ready[1] && n < 100) begin @(negedge clk); n++; end
    check("stall_rdy_timeout", 32'(n < 100), 1);
    stall[1] = 1'b1; drive_req();
    n = 0;
    while (!rx_valid && n < 100) begin @(negedge clk); n++; end
    check("stall_rx_timeout", 32'(n < 100), 1);
    bus_act = 0; cs_bad = 0; gnt_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (periph_sel) bus_act++;
      if (cs_n != 3'b101) cs_bad++;
      if (gnt != 3'b010) gnt_bad++;
    end
    check("stall_bus", bus_act, 0);
    check("stall_cs", cs_bad, 0);
    check("stall_gnt", gnt_bad, 0);
    check("stall_rdy", rdy_n[1], 1);
    stall[1] = 1'b0; drive_req();
    wait_done("stall", 300);
    check("stall_ctrl", (ctrl_log.size() > 0) ? ctrl_log[0] : 8'hEE, 8'h85);
    check("stall_rx0", rxd_at(0), 8'hE1);
    check("stall_rx1", rxd_at(1), 8'hD2);

    // RXNE never set on requester 2
    clear_logs();
    rxne_dis = 1'b1;
    cfg[23:16] = 8'h07;
    tb_byte[2][0] = 8'h77; tb_lastf[2][0] = 1'b0;
    tb_byte[2][1] = 8'h78; tb_lastf[2][1] = 1'b1; n_b[2] = 2;
    drive_req();
`ifdef SPI_ARB_TIMEOUT_EN
    n = 0;
    while (!rx_valid && n < 200) begin @(negedge clk); n++; end
    check("tmo_rx_timeout", 32'(n < 200), 1);
    check("tmo_err", rx_err, 1'b1);
    check("tmo_data", rx_data, 8'h00);
    check("tmo_polls", poll_n, 16);
    n = 0;
    while (cs_n != 3'b111 && n < 50) begin @(negedge clk); n++; end
    check("tmo_cs_timeout", 32'(n < 50), 1);
    check("tmo_gnt", gnt, 3'b000);
    check("tmo_ctrl_dis", (ctrl_log.size() > 1) ? ctrl_log[1] : 8'hEE, 8'h00);
    check("tmo_rdy", rdy_n[2], 1);
    repeat (8) @(negedge clk);
`else
    repeat (1000) @(negedge clk);
    check("poll_oe", {bus_oe, periph_addr}, 3'b101);
    check("poll_cs", cs_n, 3'b011);
    check("poll_gnt", gnt, 3'b100);
    check("poll_norx", rx_d.size(), 0);
`endif

    // asynchronous reset in the middle of a transaction
    n_reset = 1'b0;
    #1;
    check("arst_cs_n", cs_n, 3'b111);
    check("arst_gnt", gnt, 3'b000);
    check("arst_strobes", {periph_sel, bus_we, bus_oe}, 3'b000);
    clear_logs(); drive_req();
    rxne_dis = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // zero setup / hold instance, one byte
    b_cfg = 24'h01; b_tx_data = 24'h10; b_tx_last = 3'b001; b_tx_valid = 3'b001; b_req = 3'b001;
    n = 0;
    while (!b_dis_seen && n < 100) begin @(negedge clk); n++; end
    check("zero_timeout", 32'(n < 100), 1);
    @(negedge clk);
    check("zero_setup", b_wr_cyc - b_cfg_cyc, 1);
    check("zero_hold", b_dis_cyc - b_rd_cyc, 1);
    check("zero_rx", b_rx, 8'h99);
    check("zero_cs_n", b_cs_n, 3'b111);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
